// File: rtl/fifo_ctrl_1024x8.sv
// Streaming FIFO controller wrapped around an external 1024x8 RAM with a
// 1-cycle read latency; a 2-entry output buffer keeps one pop per cycle.
module fifo_ctrl_1024x8 #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 1024,
  parameter int AFULL_TH  = 1016,
  parameter int AEMPTY_TH = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Flush,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              In_Valid,
  output logic              In_Ready,
  output logic [DATA_W-1:0] Out_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [ADDR_W-1:0] WA,
  output logic [DATA_W-1:0] WD,
  output logic              WEN,
  output logic              WClk_En,
  output logic [ADDR_W-1:0] RA,
  output logic              RClk_En,
  input  logic [DATA_W-1:0] RD,
  output logic [ADDR_W:0]   Count,
  output logic              Almost_Full,
  output logic              Almost_Empty
);
  localparam logic [ADDR_W:0] FULL   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AE_LVL = (ADDR_W+1)'(AEMPTY_TH);

  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   mem_cnt, cnt_nxt;
  logic              rd_pend;
  logic [DATA_W-1:0] b0, b1, b0_n, b1_n;
  logic [1:0]        buf_cnt, bc_p, buf_n;
  logic [2:0]        occ;
  logic              live, push, pop, issue;

  assign live  = Rst_n & ~Flush;
  assign push  = In_Valid & In_Ready;
  assign pop   = Out_Valid & Out_Ready;
  // Only issue a read if the word is guaranteed a buffer slot on arrival.
  assign occ   = {1'b0, buf_cnt} + {2'b0, rd_pend} - {2'b0, pop};
  assign issue = (mem_cnt != '0) && (occ < 3'd2);

  assign WEN       = push & live;
  assign WClk_En   = WEN;
  assign WA        = wptr;
  assign WD        = In_Data;
  assign RA        = rptr;
  assign RClk_En   = issue & live;
  assign Out_Valid = (buf_cnt != 2'd0);
  assign Out_Data  = b0;

  assign cnt_nxt      = Count + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
  assign Almost_Full  = (Count >= AF_LVL);
  assign Almost_Empty = (Count <= AE_LVL);

  // Pop shifts the head out first; a returning read fills the first free slot.
  always_comb begin
    bc_p = buf_cnt - {1'b0, pop};
    b0_n = pop ? b1 : b0;
    b1_n = b1;
    if (rd_pend) begin
      if (bc_p == 2'd0) b0_n = RD;
      else              b1_n = RD;
    end
    buf_n = bc_p + {1'b0, rd_pend};
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n || Flush) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      rd_pend  <= 1'b0;
      buf_cnt  <= 2'd0;
      b0       <= '0;
      b1       <= '0;
      Count    <= '0;
      In_Ready <= 1'b1;
    end else begin
      wptr     <= wptr + ADDR_W'(push);
      rptr     <= rptr + ADDR_W'(issue);
      mem_cnt  <= mem_cnt + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, issue};
      rd_pend  <= issue;
      buf_cnt  <= buf_n;
      b0       <= b0_n;
      b1       <= b1_n;
      Count    <= cnt_nxt;
      In_Ready <= (cnt_nxt != FULL);
    end
  end
endmodule
